store_buffer: RTL and testbench
===============================

STORE_BUFFER -- requirements
Module: store_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning the number of buffered stores; legal values are powers of two, at least 2.
REQ-002 SHALL have port clk_i  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_i  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port req_valid_i  input  1  CPU MEM-stage request valid.
REQ-005 SHALL have port req_write_i  input  1  1 = store, 0 = load.
REQ-006 SHALL have ports req_addr_i and req_data_i  input  32 each  request address and store data.
REQ-007 SHALL have port req_ready_o  output  1  request accepted this cycle; 0 = stall the pipeline.
REQ-008 SHALL have port load_data_o  output  32  load result, valid in the same cycle as the load.
REQ-009 SHALL have port load_hit_o  output  1  load result was forwarded from the buffer.
REQ-010 SHALL have ports mem_addr_o and mem_data_o  output  32 each  data-memory address and write data.
REQ-011 SHALL have ports mem_read_o and mem_write_o  output  1 each  data-memory read and write strobes.
REQ-012 SHALL have port mem_data_i  input  32  data-memory read data (combinational).
REQ-013 SHALL have port mem_ready_i  input  1  data memory accepts a write this cycle.
REQ-014 SHALL have port flush_i  input  1  request to drain all entries.
REQ-015 SHALL have port flush_done_o  output  1  one-cycle pulse when a flush completes.
REQ-016 SHALL have ports full_o and empty_o  output  1 each, and count_o  output  clog2(DEPTH)+1  occupancy.

Function
REQ-017 SHALL hold stores in a circular FIFO of {addr, data}, with head and tail pointers wrapping modulo DEPTH.
REQ-018 SHALL drain the head entry when state=RUN or FLUSH, the buffer is not empty, and no load is presented: mem_write_o=1, mem_addr_o/mem_data_o = head entry; the entry pops on the edge only if mem_ready_i=1.
REQ-019 SHALL, for a load (req_valid_i=1, req_write_i=0) in RUN: set req_ready_o=1, mem_read_o=1, mem_addr_o=req_addr_i, mem_write_o=0; the drain is suppressed that cycle because the memory has a single address port.
REQ-020 SHALL forward on loads: if any valid entry's full 32-bit address equals req_addr_i, load_data_o = data of the youngest match and load_hit_o=1; otherwise load_data_o = mem_data_i and load_hit_o=0.
REQ-021 SHALL accept a store in RUN when the buffer is not full, or when it is full and a pop occurs in the same cycle; otherwise req_ready_o=0 and no state changes for the request.
REQ-022 SHALL handle a simultaneous push and pop with count unchanged; a store to an address already buffered SHALL create a new entry (no merging).
REQ-023 SHALL drive req_ready_o=1 when req_valid_i=0, and load_data_o=0, load_hit_o=0, mem_read_o=0 whenever no load is presented.
REQ-024 SHALL implement FSM RUN -> FLUSH on flush_i=1 in RUN; FLUSH -> DONE when the last entry pops (or immediately if empty); DONE -> RUN after exactly one cycle.
REQ-025 SHALL hold req_ready_o=0 for all requests in FLUSH and DONE, and assert flush_done_o only in DONE.
REQ-026 SHALL keep full_o = (count==DEPTH), empty_o = (count==0), and count_o equal to the registered occupancy.

Reset
REQ-027 SHALL, on rst_i=1 at a clock edge, clear count, head and tail to 0 and set state to RUN; entry contents need not be cleared.
REQ-028 SHALL, while rst_i=1, drive every output to 0 except req_ready_o=1 and empty_o=1.
REQ-029 SHALL, when reset is asserted mid-flush or mid-drain, discard pending stores without completing them; flush_done_o is not pulsed.

Structure
REQ-030 SHALL place the FSM state encoding (RUN, FLUSH, DONE) and the 32-bit word width constant in a shared package, cpu_pkg.
REQ-031 SHALL isolate the youngest-match address CAM in one sub-module, sb_match, taking the entries, valid mask and head pointer, and returning hit and index.

Verification
REQ-032 SHALL cover: store 0x10<-0xAAAA, then load 0x10 with mem_ready_i=0 -> load_hit_o=1, load_data_o=0xAAAA, mem_write_o=0 in the load cycle.
REQ-033 SHALL cover: stores 0x20<-1 then 0x20<-2, then load 0x20 -> load_data_o=2 (youngest match).
REQ-034 SHALL cover: mem_ready_i=0 with 4 stores accepted, so full_o=1; a 5th store -> req_ready_o=0; with mem_ready_i=1 in the same cycle -> accepted and count_o stays 4.
REQ-035 SHALL cover: 3 entries, flush_i pulse, mem_ready_i=1 -> 3 consecutive mem_write_o cycles in FIFO order, then flush_done_o high for exactly 1 cycle, then req_ready_o=1.
REQ-036 SHALL cover: rst_i asserted mid-flush with 2 entries -> next cycle count_o=0, empty_o=1, mem_write_o=0, no flush_done_o pulse.
REQ-037 SHALL cover: a load to 0x30 with no match while mem_data_i=0x1234 -> load_hit_o=0, load_data_o=0x1234, mem_read_o=1, mem_addr_o=0x30.

Source files
------------

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared word width, store-buffer FSM encoding and entry layout
package cpu_pkg;
    localparam int WORD_W = 32;
    typedef logic [WORD_W-1:0] word_t;
    typedef enum logic [1:0] {RUN, FLUSH, DONE} sb_state_e;
    typedef struct packed {
        word_t addr;
        word_t data;
    } sb_entry_t;
endpackage

// File: rtl/store_buffer_if.sv
// store_buffer_if: CPU request port and data-memory bus of the store buffer
interface store_buffer_if;
    import cpu_pkg::*;
    logic  req_valid_i;
    logic  req_write_i;
    word_t req_addr_i;
    word_t req_data_i;
    logic  req_ready_o;
    word_t load_data_o;
    logic  load_hit_o;
    word_t mem_addr_o;
    word_t mem_data_o;
    logic  mem_read_o;
    logic  mem_write_o;
    word_t mem_data_i;
    logic  mem_ready_i;
    modport slave (
        input  req_valid_i, req_write_i, req_addr_i, req_data_i, mem_data_i, mem_ready_i,
        output req_ready_o, load_data_o, load_hit_o, mem_addr_o, mem_data_o, mem_read_o, mem_write_o
    );
    modport master (
        output req_valid_i, req_write_i, req_addr_i, req_data_i, mem_data_i, mem_ready_i,
        input  req_ready_o, load_data_o, load_hit_o, mem_addr_o, mem_data_o, mem_read_o, mem_write_o
    );
endinterface

// File: rtl/sb_match.sv
// sb_match: youngest-match address CAM, scanning entries oldest (head) to youngest
module sb_match
    import cpu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  word_t                      addrs [DEPTH],
    input  logic [DEPTH-1:0]           valid,
    input  logic [$clog2(DEPTH)-1:0]   head,
    input  word_t                      addr,
    output logic                       hit,
    output logic [$clog2(DEPTH)-1:0]   idx
);
    localparam int PW = $clog2(DEPTH);
    logic [PW-1:0] j;
    always_comb begin
        hit = 1'b0;
        idx = head;
        j   = head;
        for (int k = 0; k < DEPTH; k++) begin
            j = head + PW'(k);
            if (valid[j] && addrs[j] == addr) begin
                hit = 1'b1;
                idx = j;
            end
        end
    end
endmodule

// File: rtl/store_buffer.sv
// store_buffer: circular store FIFO draining to data memory, with load forwarding and flush
module store_buffer
    import cpu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    store_buffer_if.slave          bus,
    input  logic                   flush_i,
    output logic                   flush_done_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);
    localparam int PW = $clog2(DEPTH);
    typedef logic [PW-1:0] ptr_t;
    typedef logic [PW:0]   cnt_t;

    sb_state_e        state_q, state_d;
    ptr_t             head_q, head_d, tail_q, tail_d;
    cnt_t             count_q, count_d;
    sb_entry_t        entry_q [DEPTH];
    sb_entry_t        entry_d [DEPTH];
    word_t            entry_addr [DEPTH];
    logic [DEPTH-1:0] valid;
    ptr_t             off;
    logic             hit;
    ptr_t             hit_idx;
    logic             live, run, is_load, load_act, is_empty, is_full, drain, pop, push;

    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= RUN;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q == RUN   ? (flush_i ? FLUSH : RUN) :
                  state_q == FLUSH ? ((is_empty || (pop && count_q == cnt_t'(1))) ? DONE : FLUSH) :
                                     RUN;
    end

    // a load owns the single memory address port, so it pre-empts the drain
    always_comb begin
        live     = ~rst_i;
        run      = state_q == RUN;
        is_load  = bus.req_valid_i & ~bus.req_write_i;
        load_act = run & is_load;
        is_empty = count_q == '0;
        is_full  = count_q == cnt_t'(DEPTH);
        drain    = (run | state_q == FLUSH) & ~is_empty & ~load_act;
        pop      = drain & bus.mem_ready_i;
        push     = run & bus.req_valid_i & bus.req_write_i & (~is_full | pop);
    end

    always_comb begin
        off = '0;
        for (int i = 0; i < DEPTH; i++) begin
            off           = ptr_t'(i) - head_q;
            valid[i]      = {1'b0, off} < count_q;
            entry_addr[i] = entry_q[i].addr;
        end
    end

    sb_match #(.DEPTH(DEPTH)) u_match (
        .addrs (entry_addr),
        .valid (valid),
        .head  (head_q),
        .addr  (bus.req_addr_i),
        .hit   (hit),
        .idx   (hit_idx)
    );

    always_comb begin
        head_d  = pop  ? head_q + ptr_t'(1) : head_q;
        tail_d  = push ? tail_q + ptr_t'(1) : tail_q;
        count_d = count_q + cnt_t'(push) - cnt_t'(pop);
        entry_d = entry_q;
        if (push) entry_d[tail_q] = {bus.req_addr_i, bus.req_data_i};
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk_i) entry_q <= entry_d;

    assign bus.req_ready_o = rst_i | ~bus.req_valid_i | (run & (is_load | push));
    assign bus.mem_read_o  = live & load_act;
    assign bus.mem_write_o = live & drain;
    assign bus.mem_addr_o  = ~live ? '0 : load_act ? bus.req_addr_i : drain ? entry_q[head_q].addr : '0;
    assign bus.mem_data_o  = (live & drain) ? entry_q[head_q].data : '0;
    assign bus.load_hit_o  = live & load_act & hit;
    assign bus.load_data_o = ~(live & load_act) ? '0 : hit ? entry_q[hit_idx].data : bus.mem_data_i;
    assign flush_done_o    = live & (state_q == DONE);
    assign full_o          = live & is_full;
    assign empty_o         = rst_i | is_empty;
    assign count_o         = live ? count_q : '0;
endmodule

// File: tb/tb_store_buffer.sv
// tb_store_buffer: directed and random stimulus against a queue-based reference model
module tb_store_buffer;
    localparam int DEPTH = 4;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } ent_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       flush;
    logic       flush_done, full, empty;
    logic [2:0] count;
    int         checks = 0;
    int         errors = 0;

    ent_t        q[$];
    int          mode = 0;
    logic        m_pop, m_push, m_fl;
    logic [31:0] m_a, m_d;

    store_buffer_if bus();

    store_buffer #(.DEPTH(DEPTH)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .bus          (bus),
        .flush_i      (flush),
        .flush_done_o (flush_done),
        .full_o       (full),
        .empty_o      (empty),
        .count_o      (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, w, input logic [31:0] a, d, input logic mr, fl, input logic [31:0] md);
        bus.req_valid_i = v;
        bus.req_write_i = w;
        bus.req_addr_i  = a;
        bus.req_data_i  = d;
        bus.mem_ready_i = mr;
        bus.mem_data_i  = md;
        flush           = fl;
    endtask

    task automatic step(input logic v, w, input logic [31:0] a, d, input logic mr, fl, input logic [31:0] md);
        logic        load, drain, hit;
        logic [31:0] hd;
        rst = 1'b0;
        drive(v, w, a, d, mr, fl, md);
        #1;
        load  = v && !w && mode == 0;
        drain = mode != 2 && q.size() > 0 && !load;
        hit   = 1'b0;
        hd    = '0;
        for (int k = q.size() - 1; k >= 0; k--)
            if (!hit && q[k].addr == a) begin
                hit = 1'b1;
                hd  = q[k].data;
            end
        m_pop  = drain && mr;
        m_push = mode == 0 && v && w && (q.size() < DEPTH || m_pop);
        m_fl   = fl;
        m_a    = a;
        m_d    = d;
        chk("req_ready", 32'(bus.req_ready_o), 32'(!v || (mode == 0 && (!w || m_push))));
        chk("load_hit", 32'(bus.load_hit_o), 32'(load && hit));
        chk("load_data", bus.load_data_o, !load ? 32'h0 : hit ? hd : md);
        chk("mem_read", 32'(bus.mem_read_o), 32'(load));
        chk("mem_write", 32'(bus.mem_write_o), 32'(drain));
        chk("mem_addr", bus.mem_addr_o, load ? a : drain ? q[0].addr : 32'h0);
        chk("mem_data", bus.mem_data_o, drain ? q[0].data : 32'h0);
        chk("flush_done", 32'(flush_done), 32'(mode == 2));
        chk("full", 32'(full), 32'(q.size() == DEPTH));
        chk("empty", 32'(empty), 32'(q.size() == 0));
        chk("count", 32'(count), 32'(q.size()));
    endtask

    task automatic adv();
        @(posedge clk);
        if (m_pop) void'(q.pop_front());
        if (m_push) q.push_back('{m_a, m_d});
        if (mode == 0) mode = m_fl ? 1 : 0;
        else if (mode == 1) mode = q.size() == 0 ? 2 : 1;
        else mode = 0;
        @(negedge clk);
    endtask

    task automatic rst_step(input logic v, w, input logic [31:0] a, input logic mr, fl);
        rst = 1'b1;
        drive(v, w, a, $urandom, mr, fl, $urandom);
        #1;
        chk("rst_ready", 32'(bus.req_ready_o), 32'd1);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_mem_write", 32'(bus.mem_write_o), 32'd0);
        chk("rst_mem_read", 32'(bus.mem_read_o), 32'd0);
        chk("rst_mem_addr", bus.mem_addr_o, 32'd0);
        chk("rst_mem_data", bus.mem_data_o, 32'd0);
        chk("rst_load_hit", 32'(bus.load_hit_o), 32'd0);
        chk("rst_load_data", bus.load_data_o, 32'd0);
        chk("rst_flush_done", 32'(flush_done), 32'd0);
        @(posedge clk);
        q.delete();
        mode = 0;
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst_step(1, 0, 32'h10, 1, 0);
        rst_step(0, 0, 32'h0, 0, 1);
        // store then forwarded load with memory stalled
        step(1, 1, 32'h10, 32'hAAAA, 0, 0, $urandom); adv();
        step(1, 0, 32'h10, 0, 0, 0, 32'h5555);
        chk("fwd_hit", 32'(bus.load_hit_o), 32'd1);
        chk("fwd_data", bus.load_data_o, 32'hAAAA);
        chk("fwd_no_write", 32'(bus.mem_write_o), 32'd0);
        adv();
        // youngest match wins
        step(1, 1, 32'h20, 32'h1, 0, 0, $urandom); adv();
        step(1, 1, 32'h20, 32'h2, 0, 0, $urandom); adv();
        step(1, 0, 32'h20, 0, 0, 0, $urandom);
        chk("young_data", bus.load_data_o, 32'h2);
        adv();
        // miss reads memory
        step(1, 0, 32'h30, 0, 0, 0, 32'h1234);
        chk("miss_hit", 32'(bus.load_hit_o), 32'd0);
        chk("miss_data", bus.load_data_o, 32'h1234);
        chk("miss_read", 32'(bus.mem_read_o), 32'd1);
        chk("miss_addr", bus.mem_addr_o, 32'h30);
        adv();
        // full buffer: stall, then push with simultaneous pop
        step(1, 1, 32'h40, 32'h4, 0, 0, $urandom); adv();
        step(1, 1, 32'h50, 32'h5, 0, 0, $urandom);
        chk("full_flag", 32'(full), 32'd1);
        chk("full_stall", 32'(bus.req_ready_o), 32'd0);
        adv();
        step(1, 1, 32'h50, 32'h5, 1, 0, $urandom);
        chk("full_popaccept", 32'(bus.req_ready_o), 32'd1);
        adv();
        step(0, 0, 0, 0, 0, 0, $urandom);
        chk("full_count", 32'(count), 32'd4);
        adv();
        step(0, 0, 0, 0, 1, 0, $urandom); adv();
        // flush of three entries
        step(0, 0, 0, 0, 1, 1, $urandom);
        chk("fl_w1", bus.mem_addr_o, 32'h20);
        adv();
        step(0, 0, 0, 0, 1, 0, $urandom);
        chk("fl_w2", bus.mem_addr_o, 32'h40);
        adv();
        step(0, 0, 0, 0, 1, 0, $urandom);
        chk("fl_w3", bus.mem_addr_o, 32'h50);
        adv();
        step(1, 1, 32'h60, 32'h6, 0, 0, $urandom);
        chk("fl_done", 32'(flush_done), 32'd1);
        chk("fl_done_stall", 32'(bus.req_ready_o), 32'd0);
        adv();
        step(1, 1, 32'h60, 32'h6, 0, 0, $urandom);
        chk("fl_done_once", 32'(flush_done), 32'd0);
        chk("fl_ready", 32'(bus.req_ready_o), 32'd1);
        adv();
        // reset in the middle of a flush
        step(1, 1, 32'h70, 32'h7, 0, 0, $urandom); adv();
        step(0, 0, 0, 0, 0, 1, $urandom); adv();
        step(1, 1, 32'h80, 32'h8, 0, 0, $urandom); adv();
        rst_step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 0, $urandom);
        chk("rstfl_count", 32'(count), 32'd0);
        chk("rstfl_empty", 32'(empty), 32'd1);
        chk("rstfl_write", 32'(bus.mem_write_o), 32'd0);
        chk("rstfl_done", 32'(flush_done), 32'd0);
        adv();
        step(0, 0, 0, 0, 1, 0, $urandom);
        chk("rstfl_done2", 32'(flush_done), 32'd0);
        adv();
        for (int n = 0; n < 400; n++) begin
            if ($urandom % 64 == 0)
                rst_step($urandom % 2, $urandom % 2, 32'h100, $urandom % 2, 0);
            else begin
                step($urandom % 2, $urandom % 2, 32'h100 + 32'(($urandom % 4) * 4), $urandom,
                     $urandom % 2, ($urandom % 16) == 0, $urandom);
                adv();
            end
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
